vec_pack_mbank_fifo: RTL and testbench
======================================

Name: vec_pack_mbank_fifo

Overview:
- Parametrised successor to the s8 vector packing FIFO in the MMA subsystem.
- Accepts VLEN-element vectors of EW-bit elements in batches and stores each batch in one of NBANK row banks.
- Streams each closed batch, in closure order, as OW-bit words with per-element masks after a request/ack exchange that supplies the valid column count.
- Adds input backpressure, an explicit batch end, configurable element and output widths, and more than two banks.

Parameters:
- VLEN, 16: elements per input vector; power of 2.
- EW, 8: element width in bits; 8 or 16.
- OW, 32: output word width; multiple of EW; divides VLEN*EW.
- NBANK, 2: number of banks; power of 2, at least 2.
- DEPTH, 16: maximum rows per bank.
- Derived: EPW=OW/EW elements per word; NCW=$clog2(VLEN+1); RW=$clog2(DEPTH+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_last  in  1  beat is the final row of the batch
- in_vec  in  VLEN*EW  element i at bits [i*EW +: EW]
- req_valid  out  1  a closed batch awaits a column count
- req_ack  in  1  host accepts the request; req_ncol is valid in the same cycle
- req_ncol  in  NCW  valid elements per row
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts the word
- out_data  out  OW  packed elements; lowest-index element in the LSBs
- out_mask  out  EPW  bit i set when element i of the word is valid
- out_row_last  out  1  last word of the current row
- out_batch_last  out  1  last word of the batch
- fifo_full  out  1  no bank is FREE
- ovf_err  out  1  sticky: a batch was auto-closed at DEPTH rows

Behaviour:
- Clock and reset: a single clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - All banks FREE; write and read pointers wb=rb=0.
  - Read FSM in IDLE.
  - All outputs 0, except in_ready=1.
  - Stored data is discarded if reset asserts mid-operation.
- Bank states: FREE -> FILL -> READY -> DRAIN -> FREE.
  - Write bank wb: on the first accepted beat a FREE bank becomes FILL.
  - A beat is accepted on in_valid & in_ready. It writes the row at the bank's row count, then increments the count.
  - in_ready = (bank wb is FREE or FILL).
- Batch close:
  - An accepted beat with in_last closes the batch: bank -> READY, row count frozen, wb = wb+1 mod NBANK.
  - The DEPTH-th accepted row without in_last also closes the batch and sets ovf_err. ovf_err clears only on reset.
- Read FSM:
  - IDLE: when bank rb is READY, go to REQ next cycle and assert req_valid.
  - REQ: hold req_valid until req_ack. On req_ack, latch ncol, bank -> DRAIN, go to STREAM; req_valid deasserts.
    - req_ncol=0 or req_ncol>VLEN is treated as VLEN.
  - STREAM: word index w runs 0..ceil(ncol/EPW)-1; row r runs 0..rows-1.
    - out_data = elements w*EPW..w*EPW+EPW-1 of row r.
    - out_mask[i] = (w*EPW+i < ncol).
    - out_row_last = (w is the final word of the row). out_batch_last = out_row_last & (r = rows-1).
  - out_valid holds and all outputs stay stable until out_ready.
  - A handshake with out_batch_last set: bank -> FREE, rb = rb+1 mod NBANK, FSM -> IDLE.
- Latency: a batch closed in cycle N raises req_valid at N+1 at the earliest. req_ack in cycle M gives out_valid at M+1. There are no bubbles inside a batch while out_ready=1.
- fifo_full: registered; equals 1 when all banks are non-FREE.
- Simultaneous events:
  - Write and read of different banks proceed concurrently.
  - A bank freed in cycle N is allocatable at N+1. in_ready rises at N+1.
  - A batch closing while another bank drains waits in READY.
- Order: batches are read in closure order. wb/rb wrap modulo NBANK.

Decomposition:
- Package vec_pack_pkg:
  - bank_state_e {FREE, FILL, READY, DRAIN}.
  - rd_state_e {IDLE, REQ, STREAM}.
  - Width helper functions for NCW, RW and the word count.
- Sub-module vec_pack_bank: holds DEPTH x VLEN*EW storage, row count and bank state. It has a write port and a combinational read-word port, and is instantiated NBANK times.
- The top level holds the pointers, read FSM, mask generation and flags.

Test Plan:
- Single batch, defaults: 3 rows with in_last on row 2, ack ncol=16 -> 12 words, each mask 4'b1111; out_row_last on words 3, 7 and 11; out_batch_last on word 11 only.
- Partial columns: 2 rows, ncol=6 -> per row, word 0 mask 1111 and word 1 mask 0011; 4 words total; row_last on words 1 and 3.
- Fill all banks: 3 batches with NBANK=2 and the host withholding ack -> fifo_full=1 and in_ready=0 after batch 2; ack batch 1 and drain it -> in_ready=1 the cycle after its batch_last.
- Overflow: 17 rows without in_last, DEPTH=16 -> first batch holds 16 rows, ovf_err=1, row 17 starts a new bank.
- Backpressure and ordering: random out_ready at 50%, EW=16, OW=64, 4 banks -> data and mask stable while stalled; batches emerge in write order; ncol=0 behaves as VLEN.
- Reset mid-STREAM: assert rst_n low -> all outputs 0 and in_ready=1 immediately; the next batch streams correctly.

Source files
------------

// File: rtl/vec_pack_pkg.sv
// Shared types and width helpers for the multi-bank vector
// packing FIFO.
package vec_pack_pkg;

    typedef enum logic [1:0] {
        FREE,
        FILL,
        READY,
        DRAIN
    } bank_state_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        STREAM
    } rd_state_e;

    function automatic int clog2_min1(input int x);
        return (x < 2) ? 1 : $clog2(x);
    endfunction

    function automatic int ncw_f(input int vlen);
        return $clog2(vlen + 1);
    endfunction

    function automatic int rw_f(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int nword_f(input int vlen, input int ew,
                                   input int ow);
        return (vlen * ew) / ow;
    endfunction

endpackage

// File: rtl/vec_pack_bank.sv
// One row bank: DEPTH x VLEN*EW storage, row count and the
// FREE/FILL/READY/DRAIN lifecycle, with a combinational word read.
module vec_pack_bank
    import vec_pack_pkg::*;
#(
    parameter  int VLEN  = 16,
    parameter  int EW    = 8,
    parameter  int OW    = 32,
    parameter  int DEPTH = 16,
    localparam int RW    = rw_f(DEPTH),
    localparam int AW    = clog2_min1(DEPTH),
    localparam int NW    = nword_f(VLEN, EW, OW),
    localparam int WW    = clog2_min1(NW)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en_i,
    input  logic               wr_close_i,
    input  logic [VLEN*EW-1:0] wr_data_i,
    input  logic               drain_i,
    input  logic               free_i,
    input  logic [AW-1:0]      rd_row_i,
    input  logic [WW-1:0]      rd_word_i,
    output logic [OW-1:0]      rd_data_o,
    output bank_state_e        state_o,
    output logic [RW-1:0]      rows_o
);

    bank_state_e        st_q, st_d;
    logic [RW-1:0]      cnt_q, cnt_d;
    logic [VLEN*EW-1:0] mem_q [DEPTH];
    logic [VLEN*EW-1:0] row;
    logic [OW-1:0]      words [NW];

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        unique case (st_q)
            FREE, FILL: begin
                if (wr_en_i) begin
                    cnt_d = cnt_q + RW'(1);
                    st_d  = wr_close_i ? READY : FILL;
                end
            end
            READY: if (drain_i) st_d = DRAIN;
            DRAIN: begin
                if (free_i) begin
                    st_d  = FREE;
                    cnt_d = '0;
                end
            end
            default: st_d = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= FREE;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: rows are only read below the row count.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[cnt_q[AW-1:0]] <= wr_data_i;
    end

    assign row = mem_q[rd_row_i];

    for (genvar g = 0; g < NW; g++) begin : g_word
        assign words[g] = row[g*OW +: OW];
    end

    assign rd_data_o = words[rd_word_i];
    assign state_o   = st_q;
    assign rows_o    = cnt_q;

endmodule

// File: rtl/vec_pack_mbank_fifo.sv
// Multi-bank vector packing FIFO: batches fill row banks in turn
// and drain in closure order as masked OW-bit words.
module vec_pack_mbank_fifo
    import vec_pack_pkg::*;
#(
    parameter  int VLEN  = 16,
    parameter  int EW    = 8,
    parameter  int OW    = 32,
    parameter  int NBANK = 2,
    parameter  int DEPTH = 16,
    localparam int EPW   = OW / EW,
    localparam int NCW   = ncw_f(VLEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [VLEN*EW-1:0] in_vec,
    output logic               req_valid,
    input  logic               req_ack,
    input  logic [NCW-1:0]     req_ncol,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OW-1:0]      out_data,
    output logic [EPW-1:0]     out_mask,
    output logic               out_row_last,
    output logic               out_batch_last,
    output logic               fifo_full,
    output logic               ovf_err
);

    localparam int RW = rw_f(DEPTH);
    localparam int AW = clog2_min1(DEPTH);
    localparam int NW = nword_f(VLEN, EW, OW);
    localparam int WW = clog2_min1(NW);
    localparam int PW = clog2_min1(NBANK);
    localparam logic [NCW-1:0] VLEN_C = NCW'(VLEN);
    localparam logic [RW-1:0]  LROW_C = RW'(DEPTH - 1);

    rd_state_e      rs_q, rs_d;
    logic [PW-1:0]  wb_q, rb_q;
    logic [NCW-1:0] ncol_q;
    logic [WW-1:0]  w_q;
    logic [RW-1:0]  r_q;
    logic           ovf_q, full_q;

    bank_state_e      st    [NBANK];
    logic [RW-1:0]    rows  [NBANK];
    logic [OW-1:0]    rdata [NBANK];
    logic [NBANK-1:0] wr_en, drain, free, nfree;

    logic acc, close, ack, hs;
    logic row_last, batch_last;
    int   nw;

    assign in_ready = (st[wb_q] == FREE) || (st[wb_q] == FILL);
    assign acc      = in_valid & in_ready;
    assign close    = acc & (in_last | (rows[wb_q] == LROW_C));
    assign ack      = (rs_q == REQ) & req_ack;
    assign hs       = out_valid & out_ready;

    for (genvar g = 0; g < NBANK; g++) begin : g_bank
        assign wr_en[g] = acc & (wb_q == PW'(g));
        assign drain[g] = ack & (rb_q == PW'(g));
        assign free[g]  = hs & batch_last & (rb_q == PW'(g));
        // Bank state one cycle ahead, so fifo_full tracks the banks.
        assign nfree[g] = ((st[g] == FREE) & ~wr_en[g]) | free[g];

        vec_pack_bank #(
            .VLEN  (VLEN),
            .EW    (EW),
            .OW    (OW),
            .DEPTH (DEPTH)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en_i    (wr_en[g]),
            .wr_close_i (close),
            .wr_data_i  (in_vec),
            .drain_i    (drain[g]),
            .free_i     (free[g]),
            .rd_row_i   (r_q[AW-1:0]),
            .rd_word_i  (w_q),
            .rd_data_o  (rdata[g]),
            .state_o    (st[g]),
            .rows_o     (rows[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q   <= IDLE;
            wb_q   <= '0;
            rb_q   <= '0;
            ncol_q <= '0;
            w_q    <= '0;
            r_q    <= '0;
            ovf_q  <= 1'b0;
            full_q <= 1'b0;
        end else begin
            rs_q   <= rs_d;
            full_q <= ~|nfree;
            if (close) wb_q <= wb_q + PW'(1);
            if (hs && batch_last) rb_q <= rb_q + PW'(1);
            if (acc && !in_last && rows[wb_q] == LROW_C) ovf_q <= 1'b1;
            if (ack) begin
                ncol_q <= (req_ncol == '0 || req_ncol > VLEN_C)
                          ? VLEN_C : req_ncol;
                w_q    <= '0;
                r_q    <= '0;
            end else if (hs) begin
                if (row_last) begin
                    w_q <= '0;
                    r_q <= batch_last ? '0 : r_q + RW'(1);
                end else begin
                    w_q <= w_q + WW'(1);
                end
            end
        end
    end

    // A batch closing into rb this cycle counts as READY already.
    always_comb begin
        rs_d = rs_q;
        unique case (rs_q)
            IDLE: begin
                if (st[rb_q] == READY || (close && wb_q == rb_q))
                    rs_d = REQ;
            end
            REQ:     if (req_ack) rs_d = STREAM;
            STREAM:  if (hs && batch_last) rs_d = IDLE;
            default: rs_d = IDLE;
        endcase
    end

    always_comb begin
        nw             = (int'(ncol_q) + EPW - 1) / EPW;
        req_valid      = (rs_q == REQ);
        out_valid      = (rs_q == STREAM);
        row_last       = out_valid && (int'(w_q) == nw - 1);
        batch_last     = row_last && (r_q == rows[rb_q] - RW'(1));
        out_row_last   = row_last;
        out_batch_last = batch_last;
        out_data       = out_valid ? rdata[rb_q] : '0;
        out_mask       = '0;
        for (int i = 0; i < EPW; i++) begin
            out_mask[i] = out_valid &&
                          (int'(w_q) * EPW + i < int'(ncol_q));
        end
    end

    assign fifo_full = full_q;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_vec_pack_mbank_fifo.sv
// Directed bench for vec_pack_mbank_fifo: default instance plus a
// 16-bit / 64-bit / 4-bank instance.
module tb_vec_pack_mbank_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic         in_valid, in_ready, in_last;
    logic [127:0] in_vec;
    logic         req_valid, req_ack;
    logic [4:0]   req_ncol;
    logic         out_valid, out_ready;
    logic [31:0]  out_data;
    logic [3:0]   out_mask;
    logic         out_row_last, out_batch_last, fifo_full, ovf_err;

    logic         b_in_valid, b_in_ready, b_in_last;
    logic [255:0] b_in_vec;
    logic         b_req_valid, b_req_ack;
    logic [4:0]   b_req_ncol;
    logic         b_out_valid, b_out_ready;
    logic [63:0]  b_out_data;
    logic [3:0]   b_out_mask;
    logic         b_row_last, b_batch_last, b_full, b_ovf;

    vec_pack_mbank_fifo u0 (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_last        (in_last),
        .in_vec         (in_vec),
        .req_valid      (req_valid),
        .req_ack        (req_ack),
        .req_ncol       (req_ncol),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_mask       (out_mask),
        .out_row_last   (out_row_last),
        .out_batch_last (out_batch_last),
        .fifo_full      (fifo_full),
        .ovf_err        (ovf_err)
    );

    vec_pack_mbank_fifo #(
        .VLEN(16), .EW(16), .OW(64), .NBANK(4), .DEPTH(16)
    ) u1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (b_in_valid),
        .in_ready       (b_in_ready),
        .in_last        (b_in_last),
        .in_vec         (b_in_vec),
        .req_valid      (b_req_valid),
        .req_ack        (b_req_ack),
        .req_ncol       (b_req_ncol),
        .out_valid      (b_out_valid),
        .out_ready      (b_out_ready),
        .out_data       (b_out_data),
        .out_mask       (b_out_mask),
        .out_row_last   (b_row_last),
        .out_batch_last (b_batch_last),
        .fifo_full      (b_full),
        .ovf_err        (b_ovf)
    );

    typedef struct {
        logic        rdy;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        rl;
        logic        bl;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pat8(input int tag);
        logic [127:0] v;
        for (int j = 0; j < 16; j++) v[j*8 +: 8] = 8'(tag * 16 + j);
        return v;
    endfunction

    function automatic logic [255:0] pat16(input int tag);
        logic [255:0] v;
        for (int j = 0; j < 16; j++)
            v[j*16 +: 16] = 16'(tag * 256 + j * 17 + 1);
        return v;
    endfunction

    function automatic vec_t mk(input logic rdy, input int t, input int w,
                                input logic [3:0] m, input logic rl,
                                input logic bl);
        vec_t v;
        v.rdy  = rdy;
        v.data = {8'(t*16 + 4*w + 3), 8'(t*16 + 4*w + 2),
                  8'(t*16 + 4*w + 1), 8'(t*16 + 4*w)};
        v.mask = m;
        v.rl   = rl;
        v.bl   = bl;
        return v;
    endfunction

    task automatic beat(input int tag, input logic last);
        in_valid = 1'b1;
        in_last  = last;
        in_vec   = pat8(tag);
        chk("in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_timeout", req_valid, 1);
    endtask

    task automatic ack(input int ncol);
        req_ack  = 1'b1;
        req_ncol = 5'(ncol);
        @(posedge clk);
        @(negedge clk);
        req_ack = 1'b0;
        chk("req_drop", req_valid, 0);
        chk("out_valid_lat", out_valid, 1);
    endtask

    task automatic apply(input int lo, input int hi);
        for (int k = lo; k < hi; k++) begin
            out_ready = tv[k].rdy;
            chk($sformatf("tv%0d_valid", k), out_valid, 1);
            chk($sformatf("tv%0d_data", k), out_data, tv[k].data);
            chk($sformatf("tv%0d_mask", k), out_mask, tv[k].mask);
            chk($sformatf("tv%0d_flags", k),
                {out_row_last, out_batch_last}, {tv[k].rl, tv[k].bl});
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("tv_idle", out_valid, 0);
    endtask

    task automatic drain0(input int tag, input int nrows, input int ncol);
        int           ncv, nw;
        logic [127:0] p;
        logic [31:0]  d;
        logic [3:0]   m;
        logic         rl, bl;
        ncv = (ncol == 0 || ncol > 16) ? 16 : ncol;
        nw  = (ncv + 3) / 4;
        out_ready = 1'b1;
        for (int r = 0; r < nrows; r++) begin
            for (int w = 0; w < nw; w++) begin
                p = pat8(tag + r);
                d = p[w*32 +: 32];
                for (int i = 0; i < 4; i++) m[i] = (w*4 + i < ncv);
                rl = (w == nw - 1);
                bl = rl && (r == nrows - 1);
                chk("d_valid", out_valid, 1);
                chk("d_data", out_data, d);
                chk("d_mask", out_mask, m);
                chk("d_flags", {out_row_last, out_batch_last}, {rl, bl});
                @(posedge clk);
                @(negedge clk);
            end
        end
        out_ready = 1'b0;
        chk("d_idle", out_valid, 0);
    endtask

    task automatic b_beat(input int tag, input logic last);
        b_in_valid = 1'b1;
        b_in_last  = last;
        b_in_vec   = pat16(tag);
        chk("b_in_ready", b_in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
    endtask

    task automatic b_ack(input int ncol);
        int n = 0;
        while (!b_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b_req_timeout", b_req_valid, 1);
        b_req_ack  = 1'b1;
        b_req_ncol = 5'(ncol);
        @(posedge clk);
        @(negedge clk);
        b_req_ack = 1'b0;
    endtask

    task automatic b_drain(input int tag, input int nrows, input int ncol);
        int           ncv, nw, n;
        logic [255:0] p;
        logic [63:0]  d;
        logic [3:0]   m;
        logic         rl, bl, rdy;
        ncv = (ncol == 0 || ncol > 16) ? 16 : ncol;
        nw  = (ncv + 3) / 4;
        for (int r = 0; r < nrows; r++) begin
            for (int w = 0; w < nw; w++) begin
                p = pat16(tag + r);
                d = p[w*64 +: 64];
                for (int i = 0; i < 4; i++) m[i] = (w*4 + i < ncv);
                rl = (w == nw - 1);
                bl = rl && (r == nrows - 1);
                n  = 0;
                do begin
                    chk("b_valid", b_out_valid, 1);
                    chk("b_data", b_out_data, d);
                    chk("b_mask", b_out_mask, m);
                    chk("b_flags", {b_row_last, b_batch_last}, {rl, bl});
                    rdy = (n >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                    b_out_ready = rdy;
                    n++;
                    @(posedge clk);
                    @(negedge clk);
                end while (!rdy);
            end
        end
        b_out_ready = 1'b0;
        chk("b_idle", b_out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        in_valid = 0; in_last = 0; in_vec = '0;
        req_ack = 0; req_ncol = '0; out_ready = 0;
        b_in_valid = 0; b_in_last = 0; b_in_vec = '0;
        b_req_ack = 0; b_req_ncol = '0; b_out_ready = 0;

        for (int r = 0; r < 3; r++)
            for (int w = 0; w < 4; w++)
                tv.push_back(mk(1'b1, r, w, 4'b1111, w == 3,
                                (r == 2) && (w == 3)));
        tv.push_back(mk(1'b0, 4, 0, 4'b1111, 1'b0, 1'b0));
        tv.push_back(mk(1'b1, 4, 0, 4'b1111, 1'b0, 1'b0));
        tv.push_back(mk(1'b1, 4, 1, 4'b0011, 1'b1, 1'b0));
        tv.push_back(mk(1'b0, 5, 0, 4'b1111, 1'b0, 1'b0));
        tv.push_back(mk(1'b1, 5, 0, 4'b1111, 1'b0, 1'b0));
        tv.push_back(mk(1'b1, 5, 1, 4'b0011, 1'b1, 1'b1));

        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mask", out_mask, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_ovf", ovf_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single batch, full columns
        beat(0, 0);
        beat(1, 0);
        chk("req_early", req_valid, 0);
        beat(2, 1);
        chk("req_lat", req_valid, 1);
        ack(16);
        apply(0, 12);

        // partial columns with stalls
        beat(4, 0);
        beat(5, 1);
        wait_req();
        ack(6);
        apply(12, 18);

        // fill both banks, then free one
        beat(10, 1);
        beat(11, 1);
        chk("full_set", fifo_full, 1);
        chk("in_ready_full", in_ready, 0);
        @(negedge clk);
        chk("in_ready_hold", in_ready, 0);
        wait_req();
        ack(4);
        drain0(10, 1, 4);
        chk("in_ready_freed", in_ready, 1);
        chk("full_clr", fifo_full, 0);
        beat(12, 1);
        wait_req();
        ack(16);
        drain0(11, 1, 16);
        wait_req();
        ack(0);
        drain0(12, 1, 0);

        // overflow at DEPTH rows
        for (int r = 0; r < 16; r++) begin
            if (r == 15) chk("ovf_before", ovf_err, 0);
            beat(r, 0);
        end
        chk("ovf_set", ovf_err, 1);
        chk("ovf_req", req_valid, 1);
        beat(7, 0);
        wait_req();
        ack(4);
        drain0(0, 16, 4);
        beat(8, 1);
        wait_req();
        ack(20);
        drain0(7, 2, 20);
        chk("ovf_sticky", ovf_err, 1);

        // wide instance: random backpressure and ordering
        b_beat(1, 0);
        b_beat(2, 1);
        b_beat(5, 1);
        b_beat(8, 0);
        b_beat(9, 0);
        b_beat(10, 1);
        chk("b_not_full", b_full, 0);
        chk("b_in_ready_3of4", b_in_ready, 1);
        b_ack(0);
        b_drain(1, 2, 0);
        b_ack(7);
        b_drain(5, 1, 7);
        b_ack(16);
        b_drain(8, 3, 16);
        chk("b_ovf", b_ovf, 0);

        // reset in the middle of a stream
        beat(3, 1);
        wait_req();
        ack(16);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("mid_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_req_valid", req_valid, 0);
        chk("mr_out_data", out_data, 0);
        chk("mr_out_mask", out_mask, 0);
        chk("mr_flags", {out_row_last, out_batch_last}, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_full", fifo_full, 0);
        chk("mr_ovf", ovf_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(6, 0);
        beat(7, 1);
        wait_req();
        ack(3);
        drain0(6, 2, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
